// File: rtl/face_mux_arbiter.sv
// Round-robin arbiter that shares the 2:1 face-nibble mux between the player-input
// path (requester 1) and the pattern-generator path (requester 2).
module face_mux_arbiter #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req1,
    input  logic       req2,
    input  logic [3:0] in1,
    input  logic [3:0] in2,
    output logic       gnt1,
    output logic       gnt2,
    output logic       select,
    output logic [3:0] sel_data,
    output logic       data_valid,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_MAX = 4'(HOLD_CYCLES);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;         // 0 = requester 1, 1 = requester 2
    logic       last_q, last_d;           // same encoding as owner
    logic [3:0] cnt_q, cnt_d;
    logic       select_q, select_d;
    logic [3:0] sel_data_q, sel_data_d;
    logic       valid_q, valid_d;

    logic       choice;
    logic       owner_req;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        select_d   = select_q;
        sel_data_d = sel_data_q;
        valid_d    = 1'b0;
        choice     = 1'b0;
        owner_req  = owner_q ? req2 : req1;

        case (state_q)
            IDLE: begin
                if (req1 || req2) begin
                    // On a tie the requester that was not served last wins.
                    choice     = (req1 && req2) ? ~last_q : req2;
                    state_d    = HOLD;
                    owner_d    = choice;
                    last_d     = choice;
                    select_d   = choice;
                    cnt_d      = 4'd1;
                    sel_data_d = choice ? in2 : in1;
                    valid_d    = 1'b1;
                end
            end
            HOLD: begin
                if (!owner_req || (cnt_q == HOLD_MAX)) begin
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;   // pretend requester 2 went last so requester 1 wins the first tie
            cnt_q      <= 4'd0;
            select_q   <= 1'b0;
            sel_data_q <= 4'd0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            select_q   <= select_d;
            sel_data_q <= sel_data_d;
            valid_q    <= valid_d;
        end
    end

    assign gnt1       = (state_q == HOLD) && !owner_q;
    assign gnt2       = (state_q == HOLD) && owner_q;
    assign select     = select_q;
    assign sel_data   = sel_data_q;
    assign data_valid = valid_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: doc/face_mux_arbiter.md
# face_mux_arbiter

Sequencing controller that shares the 4-bit 2:1 face-nibble multiplexer between two requesters.
- Requester 1 is the player-input path; requester 2 is the pattern-generator path.
- The block arbitrates round-robin, drives the multiplexer select, latches the chosen nibble into a registered output and holds the grant for a bounded number of cycles.
- It sits directly in front of the createFace mux and feeds the face display register.

## Interface
- HOLD_CYCLES, 4, maximum cycles a grant is held; legal range 1..15.
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- req1  input  1  requester 1 wants the mux; level, held until granted or abandoned.
- req2  input  1  requester 2 wants the mux; same rules as req1.
- in1  input  4  requester 1 nibble.
- in2  input  4  requester 2 nibble.
- gnt1  output  1  requester 1 owns the mux.
- gnt2  output  1  requester 2 owns the mux.
- select  output  1  mux select; 0 = in1, 1 = in2.
- sel_data  output  4  registered nibble of the most recent grant.
- data_valid  output  1  one-cycle strobe: sel_data was just loaded.
- busy  output  1  high whenever state is not IDLE.

## Operation
- States: IDLE, HOLD, GAP. Stored state: state, owner bit, last_served bit, hold counter (4 bits).
- IDLE:
  - If no request is asserted, remain in IDLE.
  - If exactly one req is high, grant that requester.
  - If both are high, grant the requester that is not last_served.
  - On the granting edge: state <= HOLD; owner <= chosen requester; select <= owner; last_served <= owner; counter <= 1; sel_data <= in(owner) as sampled that cycle; data_valid <= 1.
- HOLD:
  - gnt(owner)=1, the other grant is 0, select is stable.
  - data_valid returns to 0 after the first HOLD cycle.
  - If req(owner)=0, or counter == HOLD_CYCLES, then next state is GAP. Otherwise counter increments.
  - The other requester's req is ignored while in HOLD.
- GAP:
  - Exactly one cycle with both grants 0; select keeps its last value.
  - Next state is always IDLE.
- Consequences: two grants are never high together; a grant is never high in the same cycle as a select change.
- Fairness: under continuous dual requests the grants alternate 1, 2, 1, 2, …
- sel_data and select keep their values outside HOLD; they change only on a granting edge.
- Out-of-range HOLD_CYCLES (0 or >15) is illegal and is not checked in RTL.

## Timing
- Reset (rst=1 at an edge) sets: state=IDLE, gnt1=0, gnt2=0, select=0, sel_data=0, data_valid=0, busy=0, last_served=2 (so requester 1 wins the first tie), counter=0.
- Reset overrides everything, including mid-HOLD; the grant drops on the reset edge with no GAP cycle.
- All outputs are registered; no combinational path from inputs to outputs.
- Grant latency: req sampled high in IDLE at edge N gives gnt, select, sel_data and data_valid valid after edge N+1. That is 1 cycle.
- Grant length is min(HOLD_CYCLES, cycles until owner drops req) cycles.
- Early release:
  - req(owner) sampled low in HOLD at edge M means the grant is low after edge M+1.
  - The owner's drop is seen one cycle late, so the grant may extend one cycle past the drop.
- Turnaround: last HOLD cycle, then 1 GAP cycle, then 1 IDLE cycle, then the new grant. The minimum gap between grants is 2 cycles with both grants low.
- Back-to-back cadence for a requester held high alone with HOLD_CYCLES=H: period H+2 cycles.
- busy is high from the granting edge through GAP and low in IDLE.

## Test plan
- Reset: rst=1 for 2 cycles with req1=req2=1 → all outputs 0 and busy=0. Release rst → after 1 edge gnt1=1, select=0, data_valid=1 for one cycle.
- Single request: in2=4'hA, req2=1 for 8 cycles, HOLD_CYCLES=4 → gnt2 high exactly 4 cycles, select=1, sel_data=4'hA, then 1 GAP cycle, 1 IDLE cycle, and gnt2 again.
- Tie round-robin: req1=req2=1 continuously, in1=3, in2=C → grant sequence 1,2,1,2; sel_data alternates 3,C; data_valid pulses once per grant; never gnt1&gnt2.
- Early release: req1 dropped after 2 cycles of gnt1 with HOLD_CYCLES=8 → gnt1 low within 1 cycle of the drop; pending req2 granted after GAP+IDLE.
- Reset mid-HOLD: assert rst in the 2nd HOLD cycle → next cycle all grants 0, sel_data=0, state IDLE. A tie immediately after reset is won by requester 1.
- Input change during hold: in1 changes 5→9 while gnt1=1 → sel_data stays 5 until the next granting edge.
